reg_writeback: RTL and testbench

REG_WRITEBACK -- requirements
Module: reg_writeback

---
 rtl/reg_writeback_pkg.sv | 9 +
 rtl/wb_fifo.sv | 46 ++++
 rtl/reg_writeback.sv | 82 ++++++++
 tb/tb_reg_writeback.sv | 107 ++++++++++
 4 files changed

// File: rtl/reg_writeback_pkg.sv
// reg_writeback_pkg: shared decode-stage widths and the {addr, data} writeback entry record
package reg_writeback_pkg;
  localparam int WB_DATA_W = 16;
  localparam int WB_ADDR_W = 5;
  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: pending-write FIFO with two ordered push ports (0 older), one pop port, entries exposed oldest-first
module wb_fifo
  import reg_writeback_pkg::*;
#(
  parameter int W     = WB_ADDR_W + WB_DATA_W,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push0,
  input  logic [W-1:0]       d0,
  input  logic               push1,
  input  logic [W-1:0]       d1,
  input  logic               pop,
  output logic [W-1:0]       head,
  output logic [CW-1:0]      count,
  output logic [DEPTH*W-1:0] entries,
  output logic [DEPTH-1:0]   valid
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  logic [AW-1:0] w_slot1;
  assign w_slot1 = r_wr + AW'(push0);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (push0) r_mem[r_wr] <= d0;
      if (push1) r_mem[w_slot1] <= d1;
      r_wr    <= r_wr + AW'(push0) + AW'(push1);
      r_rd    <= r_rd + AW'(pop);
      r_count <= r_count + CW'(push0) + CW'(push1) - CW'(pop);
    end
  end
  assign head  = r_mem[r_rd];
  assign count = r_count;
  for (genvar g = 0; g < DEPTH; g++) begin : g_view
    assign entries[g*W +: W] = r_mem[r_rd + AW'(g)];
    assign valid[g]          = CW'(g) < r_count;
  end
endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: arbitrates ALU/MEM results into a FIFO, drains one per cycle to the register-file write port, with youngest-wins bypass lookup
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic [ADDR_W-1:0]        alu_addr,
  input  logic [DATA_W-1:0]        alu_data,
  output logic                     alu_ready,
  input  logic                     mem_valid,
  input  logic [ADDR_W-1:0]        mem_addr,
  input  logic [DATA_W-1:0]        mem_data,
  output logic                     mem_ready,
  output logic                     write_enable,
  output logic [ADDR_W-1:0]        write_addr,
  output logic [DATA_W-1:0]        write_data,
  input  logic [ADDR_W-1:0]        lookup_addr,
  output logic                     lookup_hit,
  output logic [DATA_W-1:0]        lookup_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int W  = ADDR_W + DATA_W;
  localparam int CW = $clog2(DEPTH) + 1;
  logic [W-1:0]       w_head;
  logic [CW-1:0]      w_count;
  logic [DEPTH*W-1:0] w_entries;
  logic [DEPTH-1:0]   w_valid;
  logic               w_mem_acc, w_alu_acc, w_pop;
  // Readiness ignores the same-cycle pop; MEM gets the last free slot over ALU.
  assign mem_ready = !rst && w_count <= CW'(DEPTH-1);
  assign alu_ready = !rst && (w_count <= CW'(DEPTH-2) || (w_count == CW'(DEPTH-1) && !mem_valid));
  assign w_mem_acc = mem_valid && mem_ready;
  assign w_alu_acc = alu_valid && alu_ready;
  assign w_pop     = !rst && w_count != '0;
  assign count     = w_count;
  wb_fifo #(.W(W), .DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push0   (w_mem_acc),
    .d0      ({mem_addr, mem_data}),
    .push1   (w_alu_acc),
    .d1      ({alu_addr, alu_data}),
    .pop     (w_pop),
    .head    (w_head),
    .count   (w_count),
    .entries (w_entries),
    .valid   (w_valid)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      write_enable <= 1'b0;
      write_addr   <= '0;
      write_data   <= '0;
    end else begin
      write_enable <= w_pop;
      if (w_pop) {write_addr, write_data} <= w_head;
    end
  end
  // The write-port register is older than every FIFO entry, so it is checked first and later matches override.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    if (write_enable && write_addr == lookup_addr) begin
      lookup_hit  = 1'b1;
      lookup_data = write_data;
    end
    for (int i = 0; i < DEPTH; i++)
      if (w_valid[i] && w_entries[i*W+DATA_W +: ADDR_W] == lookup_addr) begin
        lookup_hit  = 1'b1;
        lookup_data = w_entries[i*W +: DATA_W];
      end
    if (rst) begin
      lookup_hit  = 1'b0;
      lookup_data = '0;
    end
  end
endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: directed and random stimulus against a queue-based reference model of the writeback buffer
module tb_reg_writeback;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic alu_valid = 1'b0, mem_valid = 1'b0;
  logic [4:0] alu_addr = '0, mem_addr = '0, lookup_addr = '0;
  logic [15:0] alu_data = '0, mem_data = '0;
  logic alu_ready, mem_ready, write_enable, lookup_hit;
  logic [4:0] write_addr;
  logic [15:0] write_data, lookup_data;
  logic [2:0] count;
  typedef struct {
    logic [4:0]  a;
    logic [15:0] d;
  } ent_t;
  ent_t q[$];
  logic m_we = 1'b0;
  logic [4:0] m_wa = '0;
  logic [15:0] m_wd = '0;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  reg_writeback #(.DATA_W(16), .ADDR_W(5), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
    .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .lookup_data(lookup_data), .count(count)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input bit r, input bit av, input logic [4:0] aa, input logic [15:0] ad,
                      input bit mv, input logic [4:0] ma, input logic [15:0] md, input logic [4:0] la);
    int n;
    bit emr, ear, eh;
    logic [15:0] ed;
    ent_t e;
    @(negedge clk);
    rst = r; alu_valid = av; alu_addr = aa; alu_data = ad;
    mem_valid = mv; mem_addr = ma; mem_data = md; lookup_addr = la;
    #1;
    n   = q.size();
    emr = !r && n <= DEPTH - 1;
    ear = !r && (n <= DEPTH - 2 || (n == DEPTH - 1 && !mv));
    eh  = 1'b0;
    ed  = '0;
    if (!r) begin
      if (m_we && m_wa == la) begin eh = 1'b1; ed = m_wd; end
      foreach (q[i]) if (q[i].a == la) begin eh = 1'b1; ed = q[i].d; end
    end
    chk("mem_ready", 32'(mem_ready), 32'(emr));
    chk("alu_ready", 32'(alu_ready), 32'(ear));
    chk("count", 32'(count), 32'(n));
    chk("write_enable", 32'(write_enable), 32'(m_we));
    chk("write_addr", 32'(write_addr), 32'(m_wa));
    chk("write_data", 32'(write_data), 32'(m_wd));
    chk("lookup_hit", 32'(lookup_hit), 32'(eh));
    chk("lookup_data", 32'(lookup_data), 32'(ed));
    if (r) begin
      q.delete();
      m_we = 1'b0; m_wa = '0; m_wd = '0;
    end else begin
      if (n > 0) begin
        e = q.pop_front();
        m_we = 1'b1; m_wa = e.a; m_wd = e.d;
      end else m_we = 1'b0;
      if (mv && emr) q.push_back('{ma, md});
      if (av && ear) q.push_back('{aa, ad});
    end
    @(posedge clk);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    step(1, 1, 5'd9, 16'h9999, 1, 5'd8, 16'h8888, 5'd9);
    step(0, 1, 5'd1, 16'hF0F0, 0, 5'd0, 16'h0000, 5'd1);
    step(0, 0, 5'd0, 16'h0000, 0, 5'd0, 16'h0000, 5'd1);
    step(0, 0, 5'd0, 16'h0000, 0, 5'd0, 16'h0000, 5'd1);
    step(0, 0, 5'd0, 16'h0000, 0, 5'd0, 16'h0000, 5'd1);
    step(0, 1, 5'd3, 16'h2222, 1, 5'd2, 16'h1111, 5'd2);
    repeat (4) step(0, 0, 5'd0, 16'h0000, 0, 5'd0, 16'h0000, 5'd3);
    step(0, 1, 5'd5, 16'h0505, 1, 5'd6, 16'h0606, 5'd5);
    step(0, 1, 5'd7, 16'h0707, 1, 5'd8, 16'h0808, 5'd5);
    step(0, 1, 5'd9, 16'h0909, 1, 5'd10, 16'h0A0A, 5'd9);
    step(0, 1, 5'd11, 16'h0B0B, 0, 5'd0, 16'h0000, 5'd11);
    repeat (5) step(0, 0, 5'd0, 16'h0000, 0, 5'd0, 16'h0000, 5'd8);
    step(0, 1, 5'd4, 16'h0002, 1, 5'd4, 16'h0001, 5'd4);
    step(0, 0, 5'd0, 16'h0000, 0, 5'd0, 16'h0000, 5'd4);
    step(0, 0, 5'd0, 16'h0000, 0, 5'd0, 16'h0000, 5'd7);
    repeat (3) step(0, 0, 5'd0, 16'h0000, 0, 5'd0, 16'h0000, 5'd4);
    step(0, 1, 5'd12, 16'h1212, 1, 5'd13, 16'h1313, 5'd12);
    step(0, 1, 5'd14, 16'h1414, 1, 5'd15, 16'h1515, 5'd12);
    step(1, 1, 5'd16, 16'h1616, 1, 5'd17, 16'h1717, 5'd12);
    repeat (4) step(0, 0, 5'd0, 16'h0000, 0, 5'd0, 16'h0000, 5'd12);
    for (int i = 0; i < 20; i++) step(0, 1, 5'(i), 16'(16'hA000 + i), 0, 5'd0, 16'h0000, 5'(i));
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 99) < 3, $urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), 16'($urandom),
           $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), 16'($urandom), 5'($urandom_range(0, 7)));
    repeat (6) step(0, 0, 5'd0, 16'h0000, 0, 5'd0, 16'h0000, 5'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
